// File: rtl/load_seq_ctrl_if.sv
// load_seq_ctrl_if: load request, data-memory read port and register writeback of the load sequencer.
interface load_seq_ctrl_if #(parameter int AW = 32);
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_sel;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_rt_old;
    logic [4:0]    req_dest;
    logic          flush;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          wb_valid;
    logic [4:0]    wb_dest;
    logic [31:0]   wb_data;
    logic [3:0]    wb_be;
    logic          busy;
    logic          misalign_exc;
    logic          timeout_exc;
    modport slave (
        input  req_valid, req_sel, req_addr, req_rt_old, req_dest, flush, mem_ack, mem_rdata,
        output req_ready, mem_req, mem_addr, wb_valid, wb_dest, wb_data, wb_be, busy,
               misalign_exc, timeout_exc
    );
    modport master (
        output req_valid, req_sel, req_addr, req_rt_old, req_dest, flush, mem_ack, mem_rdata,
        input  req_ready, mem_req, mem_addr, wb_valid, wb_dest, wb_data, wb_be, busy,
               misalign_exc, timeout_exc
    );
endinterface

// File: rtl/load_seq_ctrl.sv
// load_seq_ctrl: one-at-a-time load sequencer (read, align/extend/merge, writeback beat).
// Define LSU_TIMEOUT_EN to abort a read that waits TIMEOUT_CYCLES without mem_ack.
module load_seq_ctrl #(
    parameter int AW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    load_seq_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_WB    = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_EXC   = 3'd4;

    logic [2:0]    r_state, w_next;
    logic [2:0]    r_sel;
    logic [1:0]    r_b;
    logic [31:0]   r_rt;
    logic [4:0]    r_dest;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wb_data;
    logic [3:0]    r_wb_be;
    logic          w_accept, w_mis, w_wait, w_tmo, w_capture;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_src, w_mask, w_data;
    logic [3:0]    w_be;

    assign w_accept  = bus.req_valid && r_state == S_IDLE;
    assign w_mis     = ((bus.req_sel == 3'd0 || bus.req_sel == 3'd7) && |bus.req_addr[1:0]) ||
                       ((bus.req_sel == 3'd3 || bus.req_sel == 3'd4) && bus.req_addr[0]);
    assign w_wait    = r_state == S_RD || r_state == S_DRAIN;
    assign w_capture = r_state == S_RD && bus.mem_ack && !bus.flush;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_to;
    assign w_tmo = w_wait && !bus.mem_ack && r_cnt == CW'(TIMEOUT_CYCLES - 1);
    // Staying in RD/DRAIN implies no ack this cycle; any state change restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_to  <= 1'b0;
        end else begin
            r_cnt <= (w_wait && w_next == r_state) ? r_cnt + 1'b1 : '0;
            r_to  <= w_tmo;
        end
    end
    assign bus.timeout_exc = r_to;
`else
    assign w_tmo           = 1'b0;
    assign bus.timeout_exc = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? (w_mis ? S_EXC : S_RD) : S_IDLE;
            S_RD:    w_next = bus.mem_ack ? (bus.flush ? S_IDLE : S_WB) :
                              w_tmo ? S_IDLE : bus.flush ? S_DRAIN : S_RD;
            S_DRAIN: w_next = (bus.mem_ack || w_tmo) ? S_IDLE : S_DRAIN;
            default: w_next = S_IDLE;
        endcase
    end

    // Result is formed from the live read word so it can be registered on the ack edge.
    always_comb begin
        w_byte = 8'(bus.mem_rdata >> {r_b, 3'b000});
        w_half = r_b[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        w_be   = r_sel == 3'd5 ? 4'b1111 << r_b : r_sel == 3'd6 ? 4'b1111 >> ~r_b : 4'b1111;
        case (r_sel)
            3'd1:    w_src = {{24{w_byte[7]}}, w_byte};
            3'd2:    w_src = {24'd0, w_byte};
            3'd3:    w_src = {{16{w_half[15]}}, w_half};
            3'd4:    w_src = {16'd0, w_half};
            3'd5:    w_src = bus.mem_rdata << {r_b, 3'b000};
            3'd6:    w_src = bus.mem_rdata >> {~r_b, 3'b000};
            default: w_src = bus.mem_rdata;
        endcase
        w_mask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
        w_data = (w_src & w_mask) | (r_rt & ~w_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_b       <= '0;
            r_rt      <= '0;
            r_dest    <= '0;
            r_addr    <= '0;
            r_wb_data <= '0;
            r_wb_be   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_sel  <= bus.req_sel;
                r_b    <= bus.req_addr[1:0];
                r_rt   <= bus.req_rt_old;
                r_dest <= bus.req_dest;
                r_addr <= {bus.req_addr[AW-1:2], 2'b00};
            end
            if (w_capture) begin
                r_wb_data <= w_data;
                r_wb_be   <= w_be;
            end
        end
    end

    assign bus.req_ready    = r_state == S_IDLE;
    assign bus.mem_req      = w_wait;
    assign bus.mem_addr     = r_addr;
    assign bus.wb_valid     = r_state == S_WB && !bus.flush;
    assign bus.wb_dest      = r_dest;
    assign bus.wb_data      = r_wb_data;
    assign bus.wb_be        = r_wb_be;
    assign bus.busy         = r_state != S_IDLE;
    assign bus.misalign_exc = r_state == S_EXC;
endmodule

// File: tb/tb_load_seq_ctrl.sv
// tb_load_seq_ctrl: scoreboard bench for load_seq_ctrl; expected writebacks are queued at issue.
// Builds with or without LSU_TIMEOUT_EN (DUT runs with TIMEOUT_CYCLES=4).
module tb_load_seq_ctrl;
    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        logic [3:0]  be;
    } wb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_mis = 0;
    wb_t  exp_q[$];
    logic [31:0] last_data;

    load_seq_ctrl_if #(.AW(32)) b();
    load_seq_ctrl #(.AW(32), .TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent byte-lane reference for the writeback value and mask.
    task automatic model(input logic [2:0] sel, input logic [1:0] bb, input logic [31:0] m,
                         input logic [31:0] rt, output logic [31:0] d, output logic [3:0] be);
        logic [7:0]  by;
        logic [15:0] hw;
        int k;
        by = m[8*bb +: 8];
        hw = bb[1] ? m[31:16] : m[15:0];
        d  = m;
        be = 4'hF;
        if (sel == 3'd1) d = {{24{by[7]}}, by};
        if (sel == 3'd2) d = {24'h0, by};
        if (sel == 3'd3) d = {{16{hw[15]}}, hw};
        if (sel == 3'd4) d = {16'h0, hw};
        if (sel == 3'd5 || sel == 3'd6) begin
            for (int i = 0; i < 4; i++) begin
                k = (sel == 3'd5) ? i - int'(bb) : i + 3 - int'(bb);
                be[i] = (sel == 3'd5) ? (i >= int'(bb)) : (i <= int'(bb));
                d[8*i +: 8] = be[i] ? m[8*k +: 8] : rt[8*i +: 8];
            end
        end
    endtask

    // Called just after a rising edge; returns just after the rising edge following WB.
    task automatic load(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [4:0] dest, input logic [31:0] rdata, input int waits,
                        input bit fl, input logic [31:0] edata, input logic [3:0] ebe);
        b.req_valid = 1'b1; b.req_sel = sel; b.req_addr = addr; b.req_rt_old = rt; b.req_dest = dest;
        @(negedge clk) chk("accept_ready", b.req_ready, 1);
        @(posedge clk) #1 b.req_valid = 1'b0;
        if (!fl) begin
            exp_q.push_back('{dest, edata, ebe});
            last_data = edata;
        end
        for (int i = 0; i < waits; i++) begin
            b.flush = fl && i == 0;
            @(negedge clk) chk("mem_req_wait", b.mem_req, 1);
            @(posedge clk) #1 b.flush = 1'b0;
        end
        b.mem_ack = 1'b1; b.mem_rdata = rdata; b.flush = fl && waits == 0;
        @(negedge clk) begin
            chk("mem_req_ack", b.mem_req, 1);
            chk("mem_addr", b.mem_addr, {addr[31:2], 2'b00});
        end
        @(posedge clk) #1 begin b.mem_ack = 1'b0; b.flush = 1'b0; end
        @(negedge clk) chk("wb_latency", b.wb_valid, 32'(!fl));
        @(posedge clk) #1;
    endtask

    always @(negedge clk) begin
        if (b.wb_valid) begin
            if (exp_q.size() == 0) chk("wb_unexpected", b.wb_valid, 0);
            else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_dest", b.wb_dest, e.dest);
                chk("wb_data", b.wb_data, e.data);
                chk("wb_be", b.wb_be, e.be);
            end
        end
`ifndef LSU_TIMEOUT_EN
        if (b.timeout_exc) chk("timeout_unexpected", b.timeout_exc, 0);
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, a, m, rt;
        logic [3:0]  be;
        logic [2:0]  s;
        int n;
        b.req_valid = 1'b1; b.req_sel = 3'd0; b.req_addr = 32'h100; b.req_rt_old = 0; b.req_dest = 5'd3;
        b.flush = 1'b0; b.mem_ack = 1'b0; b.mem_rdata = 0;
        repeat (3) @(negedge clk) begin
            chk("rst_ready", b.req_ready, 1);
            chk("rst_mem_req", b.mem_req, 0);
            chk("rst_wb_valid", b.wb_valid, 0);
            chk("rst_busy", b.busy, 0);
        end
        chk("rst_wb_data", b.wb_data, 0);
        chk("rst_mem_addr", b.mem_addr, 0);
        @(posedge clk) #1 rst_n = 1'b1;
        load(3'd0, 32'h100, 0, 5'd3, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D, 4'hF);
        load(3'd1, 32'h1003, 0, 5'd4, 32'h80FF_1234, 2, 0, 32'hFFFF_FF80, 4'hF);
        load(3'd5, 32'h2001, 32'hAABB_CCDD, 5'd5, 32'h1122_3344, 1, 0, 32'h2233_44DD, 4'hE);
        load(3'd6, 32'h2001, 32'hAABB_CCDD, 5'd6, 32'h1122_3344, 0, 0, 32'hAABB_1122, 4'h3);
        // misaligned word load: exception pulse, no read
        b.req_valid = 1'b1; b.req_sel = 3'd0; b.req_addr = 32'h3002; b.req_dest = 5'd7;
        @(negedge clk) chk("mis_accept", b.req_ready, 1);
        @(posedge clk) #1 b.req_valid = 1'b0;
        @(negedge clk) begin
            chk("mis_exc", b.misalign_exc, 1);
            chk("mis_no_req", b.mem_req, 0);
        end
        @(posedge clk) #1;
        @(negedge clk) begin
            chk("mis_exc_end", b.misalign_exc, 0);
            chk("mis_idle", b.req_ready, 1);
            chk("mis_no_req2", b.mem_req, 0);
            chk("wb_hold", b.wb_data, last_data);
        end
        @(posedge clk) #1;
        load(3'd3, 32'h3002, 0, 5'd8, 32'h8001_1234, 1, 0, 32'hFFFF_8001, 4'hF);
        load(3'd0, 32'h4000, 0, 5'd9, 32'h1234_5678, 3, 1, 0, 0);
        load(3'd2, 32'h4001, 0, 5'd9, 32'h1234_5678, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            s  = 3'($urandom_range(0, 7));
            a  = $urandom;
            m  = $urandom;
            rt = $urandom;
            if (s == 3'd0 || s == 3'd7) a[1:0] = 2'b00;
            if (s == 3'd3 || s == 3'd4) a[0] = 1'b0;
            model(s, a[1:0], m, rt, d, be);
            load(s, a, rt, 5'(i + 10), m, $urandom_range(0, 3), 0, d, be);
        end
        b.req_valid = 1'b1; b.req_sel = 3'd0; b.req_addr = 32'h5000; b.req_dest = 5'd1;
        @(posedge clk) #1 b.req_valid = 1'b0;
        n = 0;
`ifdef LSU_TIMEOUT_EN
        for (int i = 0; i < 20 && !b.timeout_exc; i++) begin
            @(negedge clk) if (b.mem_req) n++;
            if (!b.timeout_exc) @(posedge clk) #1;
        end
        chk("to_req_cycles", n, 4);
        chk("to_exc", b.timeout_exc, 1);
        chk("to_req_low", b.mem_req, 0);
        @(posedge clk) #1;
        @(negedge clk) begin
            chk("to_exc_end", b.timeout_exc, 0);
            chk("to_idle", b.req_ready, 1);
        end
`else
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) if (b.mem_req) n++;
            @(posedge clk) #1;
        end
        chk("hold_req_cycles", n, 10);
        b.mem_ack = 1'b1; b.flush = 1'b1;
        @(posedge clk) #1 begin b.mem_ack = 1'b0; b.flush = 1'b0; end
        @(negedge clk) begin
            chk("flush_ack_idle", b.req_ready, 1);
            chk("flush_ack_no_wb", b.wb_valid, 0);
            chk("no_timeout", b.timeout_exc, 0);
        end
`endif
        repeat (2) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/load_seq_ctrl.md
Name: load_seq_ctrl

Overview:
- Multi-cycle load sequencer between the MEM pipeline stage and a handshaked data-memory port.
- Accepts one load request at a time, issues a word-aligned memory read and waits for the acknowledge.
- Aligns, extends or merges the returned word, then presents one register-writeback beat with its byte-enable mask.
- Detects misaligned word/halfword loads and handles pipeline flush while a read is outstanding.

Parameters:
- AW, 32, memory address width
- TIMEOUT_CYCLES, 255, max cycles waiting for mem_ack; used only with LSU_TIMEOUT_EN

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- req_valid  in  1  load request present
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready
- req_sel  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 treated as LW
- req_addr  in  AW  byte address
- req_rt_old  in  32  current destination-register value, used for LWL/LWR merge
- req_dest  in  5  destination register index
- flush  in  1  squash the in-flight load
- mem_req  out  1  read strobe, held until mem_ack
- mem_addr  out  AW  {req_addr[AW-1:2],2'b00}, registered
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  32  read word
- wb_valid  out  1  one-cycle writeback pulse
- wb_dest  out  5  writeback register index
- wb_data  out  32  writeback value
- wb_be  out  4  byte enables for wb_data
- busy  out  1  state != IDLE, used as the pipeline stall
- misalign_exc  out  1  one-cycle address-error pulse
- timeout_exc  out  1  one-cycle bus-timeout pulse; tied 0 without LSU_TIMEOUT_EN

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0 except req_ready=1.
  - All latches clear.
- States: IDLE, RD, WB, DRAIN, EXC.
- IDLE, on accept:
  - Latch sel, addr[1:0], rt_old and dest.
  - Misaligned request (sel 0/7 with addr[1:0]!=0, or sel 3/4 with addr[0]!=0): go to EXC.
  - Otherwise go to RD.
- RD:
  - mem_req=1, with mem_addr stable from the first RD cycle.
  - mem_ack=1: capture mem_rdata and go to WB.
  - flush=1 without mem_ack: go to DRAIN.
  - flush=1 and mem_ack=1 in the same cycle: discard the data and go to IDLE.
- DRAIN:
  - mem_req stays 1; the bus is never abandoned.
  - On mem_ack go to IDLE with no writeback.
- WB: wb_valid=1 for exactly one cycle, then IDLE. flush in WB suppresses wb_valid.
- EXC: misalign_exc=1 for one cycle, no memory access, then IDLE.
- Latency: accept at cycle 0, mem_req from cycle 1. If mem_ack arrives in cycle k, wb_valid is in cycle k+1. Zero-wait memory gives a 3-cycle load, and a new request is accepted on the cycle after WB.
- Data path (b = addr[1:0], m = captured word):
  - LW: data=m, be=1111.
  - LB/LBU: byte m[8b+7:8b], sign-/zero-extended, be=1111.
  - LH/LHU: halfword m[16*b[1]+15:16*b[1]], sign-/zero-extended, be=1111.
  - LWL: be by b 0..3 = 1111, 1110, 1100, 1000; data = (m << 8b), enabled bytes from the shift, others from rt_old.
  - LWR: be by b 0..3 = 0001, 0011, 0111, 1111; data = (m >> 8(3-b)), enabled bytes from the shift, others from rt_old.
- wb_dest = latched dest. wb_data and wb_be are held from WB until the next WB.
- Reset asserted mid-RD drops the transaction; the memory side must tolerate a withdrawn mem_req.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to RD/DRAIN and increments each cycle without mem_ack.
  - On reaching TIMEOUT_CYCLES: mem_req drops, timeout_exc pulses one cycle, no writeback, state returns to IDLE.
  - A mem_ack arriving in the same cycle as the limit wins and the load completes normally.
- When undefined: no counter, timeout_exc=0, and RD/DRAIN wait indefinitely.

Test Plan:
- Reset with req_valid=1 held → req_ready=1, mem_req=0, wb_valid=0. First accept happens only after rst_n rises.
- LB addr=0x1003, mem_rdata=0x80FF_1234, ack after 2 wait cycles:
  - mem_addr=0x1000.
  - wb_data=0xFFFF_FF80, be=1111.
  - wb_valid exactly one cycle after ack.
- LWL addr=0x2001, rt_old=0xAABBCCDD, m=0x11223344 → wb_be=1110, wb_data=0x223344DD. LWR addr=0x2001, same values → wb_be=0011, wb_data=0xAABB1122.
- LW addr=0x3002 → misalign_exc pulse, mem_req never asserted, wb_valid=0. LH addr=0x3002 is not an error.
- flush one cycle into RD, ack 3 cycles later → mem_req held until ack, then IDLE, wb_valid never asserted.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → mem_req high 4 cycles, timeout_exc pulses, back to IDLE. Without the macro → mem_req stays high.
